// File: rtl/mem_arbiter.sv
// Two-port data-memory arbiter: pipeline port A and loader port B share one
// single-cycle memory through a fixed three-state IDLE/ACCESS/COMPLETE handshake.
module mem_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Req_A,
    input  logic              Req_B,
    input  logic              Wr_A,
    input  logic              Wr_B,
    input  logic [31:0]       Addr_A,
    input  logic [31:0]       Addr_B,
    input  logic [DATA_W-1:0] WData_A,
    input  logic [DATA_W-1:0] WData_B,
    output logic              Gnt_A,
    output logic              Gnt_B,
    output logic              Valid_A,
    output logic              Valid_B,
    output logic [DATA_W-1:0] RData_A,
    output logic [DATA_W-1:0] RData_B,
    output logic              Stall_A,
    output logic              Busy,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [DATA_W-1:0] Mem_WriteData,
    output logic              Mem_MemRead,
    output logic              Mem_MemWrite,
    input  logic [DATA_W-1:0] Mem_ReadData
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ACCESS   = 2'b01,
        ST_COMPLETE = 2'b10
    } state_t;

    state_t              r_state;
    logic                r_last_b;
    logic                r_owner_b;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_gnt_a;
    logic                r_gnt_b;
    logic                r_valid_a;
    logic                r_valid_b;
    logic [DATA_W-1:0]   r_rdata_a;
    logic [DATA_W-1:0]   r_rdata_b;
    logic                r_mem_read;
    logic                r_mem_write;
    logic                r_busy;

    logic                w_win_b;
    logic                w_sel_wr;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_unused_addr;

    assign w_unused_addr = ^{Addr_A[31:ADDR_W], Addr_B[31:ADDR_W]};

    // Winner select: a lone requester always wins, a tie goes to the port not granted last.
    always_comb begin
        w_win_b     = Req_B & (~Req_A | ~r_last_b);
        w_sel_wr    = Wr_A;
        w_sel_addr  = Addr_A[ADDR_W-1:0];
        w_sel_wdata = WData_A;
        if (w_win_b) begin
            w_sel_wr    = Wr_B;
            w_sel_addr  = Addr_B[ADDR_W-1:0];
            w_sel_wdata = WData_B;
        end else begin
            w_sel_wr    = Wr_A;
            w_sel_addr  = Addr_A[ADDR_W-1:0];
            w_sel_wdata = WData_A;
        end
    end

    // Arbitration FSM with registered grant, valid, strobe and read-data outputs.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state     <= ST_IDLE;
            r_last_b    <= 1'b1;
            r_owner_b   <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= {ADDR_W{1'b0}};
            r_wdata     <= {DATA_W{1'b0}};
            r_gnt_a     <= 1'b0;
            r_gnt_b     <= 1'b0;
            r_valid_a   <= 1'b0;
            r_valid_b   <= 1'b0;
            r_rdata_a   <= {DATA_W{1'b0}};
            r_rdata_b   <= {DATA_W{1'b0}};
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_gnt_a     <= 1'b0;
            r_gnt_b     <= 1'b0;
            r_valid_a   <= 1'b0;
            r_valid_b   <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Req_A || Req_B) begin
                        r_state     <= ST_ACCESS;
                        r_busy      <= 1'b1;
                        r_last_b    <= w_win_b;
                        r_owner_b   <= w_win_b;
                        r_wr        <= w_sel_wr;
                        r_addr      <= w_sel_addr;
                        r_wdata     <= w_sel_wdata;
                        r_gnt_a     <= ~w_win_b;
                        r_gnt_b     <= w_win_b;
                        r_mem_read  <= ~w_sel_wr;
                        r_mem_write <= w_sel_wr;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    r_state   <= ST_COMPLETE;
                    r_busy    <= 1'b1;
                    r_valid_a <= ~r_owner_b;
                    r_valid_b <= r_owner_b;
                    // Memory read data is combinational, so capture it as ACCESS ends.
                    if (!r_wr && r_owner_b) begin
                        r_rdata_b <= Mem_ReadData;
                    end else if (!r_wr) begin
                        r_rdata_a <= Mem_ReadData;
                    end else begin
                        r_rdata_a <= r_rdata_a;
                    end
                end
                ST_COMPLETE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Gnt_A         = r_gnt_a;
    assign Gnt_B         = r_gnt_b;
    assign Valid_A       = r_valid_a;
    assign Valid_B       = r_valid_b;
    assign RData_A       = r_rdata_a;
    assign RData_B       = r_rdata_b;
    assign Busy          = r_busy;
    assign Mem_Address   = r_addr;
    assign Mem_WriteData = r_wdata;
    assign Mem_MemRead   = r_mem_read;
    // Gating with reset kills a write whose ACCESS cycle is hit by reset.
    assign Mem_MemWrite  = r_mem_write & Rst_n;
    assign Stall_A       = Req_A & ~r_valid_a;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 128-word data memory.
module tb_mem_arbiter;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Req_A, Req_B, Wr_A, Wr_B;
    logic [31:0] Addr_A, Addr_B, WData_A, WData_B;
    logic        Gnt_A, Gnt_B, Valid_A, Valid_B, Stall_A, Busy;
    logic [31:0] RData_A, RData_B;
    logic [6:0]  Mem_Address;
    logic [31:0] Mem_WriteData, Mem_ReadData;
    logic        Mem_MemRead, Mem_MemWrite;

    logic [31:0] mem [0:127];
    int          n_cmp = 0;
    int          n_err = 0;

    mem_arbiter #(.ADDR_W(7), .DATA_W(32)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Req_A(Req_A), .Req_B(Req_B), .Wr_A(Wr_A), .Wr_B(Wr_B),
        .Addr_A(Addr_A), .Addr_B(Addr_B), .WData_A(WData_A), .WData_B(WData_B),
        .Gnt_A(Gnt_A), .Gnt_B(Gnt_B), .Valid_A(Valid_A), .Valid_B(Valid_B),
        .RData_A(RData_A), .RData_B(RData_B), .Stall_A(Stall_A), .Busy(Busy),
        .Mem_Address(Mem_Address), .Mem_WriteData(Mem_WriteData),
        .Mem_MemRead(Mem_MemRead), .Mem_MemWrite(Mem_MemWrite),
        .Mem_ReadData(Mem_ReadData)
    );

    always #5 Clk = ~Clk;

    // Data memory: combinational read, write on the rising edge.
    assign Mem_ReadData = mem[Mem_Address];
    always @(posedge Clk) begin
        if (Mem_MemWrite) mem[Mem_Address] <= Mem_WriteData;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic        own_a;
        int          phase;
        for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
        mem[5]    <= 32'hDEADBEEF;
        mem[3]    <= 32'hA5A5_5A5A;
        mem[1]    <= 32'h1111_1111;
        mem[2]    <= 32'h2222_2222;
        mem[32]   <= 32'h0000_0020;
        mem[33]   <= 32'h0000_0021;
        mem[34]   <= 32'h0000_0022;
        Rst_n = 1'b0; Req_A = 1'b0; Req_B = 1'b0; Wr_A = 1'b0; Wr_B = 1'b0;
        Addr_A = 32'h0; Addr_B = 32'h0; WData_A = 32'h0; WData_B = 32'h0;
        tick(); tick();
        check_val("rst_gnt",   {30'h0, Gnt_A, Gnt_B}, 32'h0);
        check_val("rst_valid", {30'h0, Valid_A, Valid_B}, 32'h0);
        check_val("rst_rdata_a", RData_A, 32'h0);
        check_val("rst_rdata_b", RData_B, 32'h0);
        check_val("rst_busy", {31'h0, Busy}, 32'h0);
        check_val("rst_addr", {25'h0, Mem_Address}, 32'h0);

        // Single read from port A
        Rst_n = 1'b1; Req_A = 1'b1; Wr_A = 1'b0; Addr_A = 32'h5;
        tick();
        check_val("rd_gnt_a", {31'h0, Gnt_A}, 32'h1);
        check_val("rd_memread", {31'h0, Mem_MemRead}, 32'h1);
        check_val("rd_addr", {25'h0, Mem_Address}, 32'h5);
        check_val("rd_stall_hi", {31'h0, Stall_A}, 32'h1);
        tick();
        check_val("rd_valid_a", {31'h0, Valid_A}, 32'h1);
        check_val("rd_rdata_a", RData_A, 32'hDEADBEEF);
        check_val("rd_stall_lo", {31'h0, Stall_A}, 32'h0);
        Req_A = 1'b0;
        tick();
        check_val("rd_idle_busy", {31'h0, Busy}, 32'h0);

        // Port B writes, port A reads it back
        Req_B = 1'b1; Wr_B = 1'b1; Addr_B = 32'h7F; WData_B = 32'h12345678;
        tick();
        check_val("wr_gnt", {30'h0, Gnt_A, Gnt_B}, 32'h1);
        check_val("wr_strobe", {30'h0, Mem_MemRead, Mem_MemWrite}, 32'h1);
        check_val("wr_wdata", Mem_WriteData, 32'h12345678);
        Req_B = 1'b0; WData_B = 32'h0;
        tick();
        check_val("wr_valid_b", {30'h0, Valid_A, Valid_B}, 32'h1);
        check_val("wr_strobe_off", {31'h0, Mem_MemWrite}, 32'h0);
        check_val("wr_mem", mem[127], 32'h12345678);
        tick();
        Req_A = 1'b1; Wr_A = 1'b0; Addr_A = 32'h7F;
        tick();
        check_val("rb_gnt_a", {31'h0, Gnt_A}, 32'h1);
        tick();
        check_val("rb_rdata_a", RData_A, 32'h12345678);
        check_val("rb_rdata_b", RData_B, 32'h0);
        Req_A = 1'b0;
        tick();

        // Upper address bits ignored
        Req_A = 1'b1; Addr_A = 32'hFFFFFF83;
        tick();
        check_val("hi_addr", {25'h0, Mem_Address}, 32'h3);
        tick();
        check_val("hi_rdata", RData_A, 32'hA5A55A5A);
        Req_A = 1'b0;
        tick();

        // Reset during a write's ACCESS cycle
        Req_A = 1'b1; Wr_A = 1'b1; Addr_A = 32'h10; WData_A = 32'hCAFEF00D;
        tick();
        check_val("ab_wr_strobe", {31'h0, Mem_MemWrite}, 32'h1);
        Rst_n = 1'b0; Req_A = 1'b0; Wr_A = 1'b0;
        #1;
        check_val("ab_wr_gated", {31'h0, Mem_MemWrite}, 32'h0);
        tick();
        check_val("ab_mem", mem[16], 32'h0);
        check_val("ab_valid", {30'h0, Valid_A, Valid_B}, 32'h0);
        check_val("ab_busy", {31'h0, Busy}, 32'h0);
        check_val("ab_rdata_a", RData_A, 32'h0);
        check_val("ab_rdata_b", RData_B, 32'h0);
        tick();
        check_val("ab_mem_later", mem[16], 32'h0);

        // Both ports requesting continuously: A,B,A,B
        Rst_n = 1'b1; Req_A = 1'b1; Req_B = 1'b1; Wr_A = 1'b0; Wr_B = 1'b0;
        Addr_A = 32'h1; Addr_B = 32'h2;
        for (int i = 1; i <= 12; i++) begin
            tick();
            phase = (i - 1) % 3;
            own_a = (((i - 1) / 3) % 2) == 0;
            check_val("rr_gnt", {30'h0, Gnt_A, Gnt_B},
                      (phase == 0) ? (own_a ? 32'h2 : 32'h1) : 32'h0);
            check_val("rr_valid", {30'h0, Valid_A, Valid_B},
                      (phase == 1) ? (own_a ? 32'h2 : 32'h1) : 32'h0);
            check_val("rr_busy", {31'h0, Busy}, (phase != 2) ? 32'h1 : 32'h0);
            check_val("rr_stall", {31'h0, Stall_A}, (phase == 1 && own_a) ? 32'h0 : 32'h1);
            if (phase == 1 && own_a) check_val("rr_rdata_a", RData_A, 32'h11111111);
            if (phase == 1 && !own_a) check_val("rr_rdata_b", RData_B, 32'h22222222);
        end
        Req_A = 1'b0; Req_B = 1'b0;
        tick();
        check_val("rr_quiet", {31'h0, Busy}, 32'h0);

        // Port B alone, three accesses after B was granted last
        Req_B = 1'b1; Wr_B = 1'b0; Addr_B = 32'h20;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("solo_gnt", {30'h0, Gnt_A, Gnt_B}, 32'h1);
            check_val("solo_addr", {25'h0, Mem_Address}, 32'h20 + k);
            Addr_B = 32'h21 + k;
            tick();
            check_val("solo_rdata_b", RData_B, 32'h20 + k);
            check_val("solo_rdata_a", RData_A, 32'h11111111);
            tick();
        end
        Req_B = 1'b0;
        tick();
        check_val("solo_idle", {31'h0, Busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
